adder_tree_csa_acc: RTL

- Parametrised, pipelined carry-save adder tree that sums I_DATA_N operands of I_DATA_W bits each, in a signed or unsigned mode.
- Adds valid qualification and multi-beat frame accumulation: per-beat tree sums are accumulated until a beat marked last, then one result is emitted.
- Sits after the per-channel sample pipeline as the generic reduction stage. Successor to the fixed 16-input tree.

---
 rtl/adder_tree_csa_acc.sv | 89 ++++++++
 1 files changed

// File: rtl/adder_tree_csa_acc.sv
// adder_tree_csa_acc: pipelined carry-save adder tree with valid qualification and multi-beat frame accumulation
module adder_tree_csa_acc #(
  parameter int I_DATA_W = 3,
  parameter int I_DATA_N = 16,
  parameter int SIGNED = 0,
  parameter int ACC_EXT_W = 4,
  parameter int CNT_W = 8,
  localparam int SUM_W = I_DATA_W + $clog2(I_DATA_N),
  localparam int O_DATA_W = SUM_W + ACC_EXT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid,
  input  logic                         i_last,
  input  logic [I_DATA_N*I_DATA_W-1:0] i_data,
  output logic                         o_valid,
  output logic [O_DATA_W-1:0]          o_data,
  output logic [CNT_W-1:0]             o_cnt
);
  function automatic int layer_n(input int s);
    int n = I_DATA_N;
    for (int k = 0; k < s; k++) n = n / 3 * 2 + n % 3;
    return n;
  endfunction
  function automatic int n_stages();
    int s = 0;
    while (layer_n(s) > 2) s++;
    return s;
  endfunction
  localparam int STAGES_N = n_stages();
  typedef logic [SUM_W-1:0] word_t;
  typedef enum logic {IDLE, ACCUM} state_t;
  function automatic word_t widen(input logic [I_DATA_W-1:0] x);
    return SIGNED != 0 ? SUM_W'($signed(x)) : SUM_W'(x);
  endfunction
  word_t lvl [STAGES_N+1][I_DATA_N];
  word_t sum;
  logic [STAGES_N+1:0] vld, lst;
  state_t state;
  logic [O_DATA_W-1:0] acc, total;
  logic [CNT_W-1:0] cnt, cnt_next;
  always_ff @(posedge clk)
    for (int i = 0; i < I_DATA_N; i++)
      lvl[0][i] <= widen(i_data[(I_DATA_N-1-i)*I_DATA_W +: I_DATA_W]);
  // layer s holds layer_n(s) live operands; unused slots are tied to zero
  for (genvar s = 0; s < STAGES_N; s++) begin : g_layer
    localparam int N = layer_n(s);
    localparam int G = N / 3;
    localparam int R = N % 3;
    always_ff @(posedge clk) begin
      for (int k = 0; k < G; k++) begin
        lvl[s+1][2*k]   <= lvl[s][3*k] ^ lvl[s][3*k+1] ^ lvl[s][3*k+2];
        lvl[s+1][2*k+1] <= ((lvl[s][3*k] & lvl[s][3*k+1]) | (lvl[s][3*k] & lvl[s][3*k+2]) |
                            (lvl[s][3*k+1] & lvl[s][3*k+2])) << 1;
      end
      for (int r = 0; r < R; r++) lvl[s+1][2*G+r] <= lvl[s][3*G+r];
      for (int j = 2*G+R; j < I_DATA_N; j++) lvl[s+1][j] <= '0;
    end
  end
  always_ff @(posedge clk) begin
    sum <= lvl[STAGES_N][0] + lvl[STAGES_N][1];
    vld <= rst ? '0 : {vld[STAGES_N:0], i_valid};
    lst <= rst ? '0 : {lst[STAGES_N:0], i_last};
  end
  always_comb begin
    total = (state == ACCUM ? acc : '0) + (SIGNED != 0 ? O_DATA_W'($signed(sum)) : O_DATA_W'(sum));
    cnt_next = (state == ACCUM ? cnt : '0) + CNT_W'(1);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      o_valid <= 1'b0;
      o_data <= '0;
      o_cnt <= '0;
    end else begin
      o_valid <= vld[STAGES_N+1] & lst[STAGES_N+1];
      if (vld[STAGES_N+1]) begin
        state <= lst[STAGES_N+1] ? IDLE : ACCUM;
        acc <= lst[STAGES_N+1] ? '0 : total;
        cnt <= lst[STAGES_N+1] ? '0 : cnt_next;
        if (lst[STAGES_N+1]) begin
          o_data <= total;
          o_cnt <= cnt_next;
        end
      end
    end
endmodule
